ddc_sample_packer: RTL and testbench

- Sits directly upstream of the UDP sender's per-DDC Rx FIFO, one instance per DDC.
- Takes 24-bit I/Q sample pairs from a DDC strobe and serialises each pair into six bytes, I then Q, MSB first.
- Writes the bytes as 9-bit FIFO words; bit 8 marks the first byte of every sample, so the downstream reader can detect and recover byte misalignment.
- Guarantees only whole samples enter the FIFO, and counts samples dropped on overflow.

---
 rtl/sdr_pkg.sv | 27 ++
 rtl/ddc_sample_skid.sv | 84 ++++++++
 rtl/ddc_sample_packer.sv | 158 +++++++++++++++
 tb/tb_ddc_sample_packer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR sample path: framing constants, the I/Q
// pair type carried between the DDC and the UDP sender, and serialiser states.
package sdr_pkg;

  localparam int BYTES_PER_SAMPLE    = 6;
  localparam int SAMPLES_PER_FRAME   = 238;
  localparam int FRAME_PAYLOAD_BYTES = 1428;
  localparam int SAMPLE_START_BIT    = 8;

  // One DDC output sample: I in the upper half, Q in the lower half.
  typedef struct packed {
    logic [23:0] i;
    logic [23:0] q;
  } iq_pair;

  // Serialiser state: IDLE, then one state per emitted byte.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4,
    ST_B4   = 3'd5,
    ST_B5   = 3'd6
  } ser_state_e;

endpackage

// File: rtl/ddc_sample_skid.sv
// Two-entry buffer of I/Q pairs between the DDC strobe and the byte
// serialiser. A push while full is ignored unless a pop frees a slot in the
// same cycle. Flush empties the buffer and wins over push/pop.
module ddc_sample_skid
  import sdr_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  iq_pair push_data,
  input  logic   pop,
  input  logic   flush,
  output iq_pair head,
  output logic   full,
  output logic   empty
);

  iq_pair     entry0_q, entry0_d;
  iq_pair     entry1_q, entry1_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push_s;
  logic       do_pop_s;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = rd_ptr_q ? entry1_q : entry0_q;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    entry0_d  = entry0_q;
    entry1_d  = entry1_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop & (count_q != 2'd0);
    do_push_s = push & ((count_q != 2'd2) | do_pop_s);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push_s) begin
        if (wr_ptr_q) begin
          entry1_d = push_data;
        end else begin
          entry0_d = push_data;
        end
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddc_sample_packer.sv
// Packs 24-bit I/Q sample pairs into six 9-bit FIFO words (I then Q, MSB
// first, bit 8 flags the first byte). A sample only starts when the FIFO has
// room for all six bytes plus a margin, so only whole samples are written.
module ddc_sample_packer
  import sdr_pkg::*;
#(
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_DEPTH  = 4096,
  parameter int USEDW_BITS  = 12,
  parameter int FIFO_MARGIN = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  sample_strobe,
  input  logic [SAMPLE_BITS-1:0] i_data,
  input  logic [SAMPLE_BITS-1:0] q_data,
  input  logic [USEDW_BITS-1:0]  fifo_wrusedw,
  output logic [8:0]            fifo_wrdata,
  output logic                  fifo_wrreq,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam logic [USEDW_BITS:0] DEPTH_W = (USEDW_BITS + 1)'(FIFO_DEPTH);
  localparam logic [USEDW_BITS:0] NEED_W  = (USEDW_BITS + 1)'(BYTES_PER_SAMPLE + FIFO_MARGIN);

  ser_state_e  state_q, state_d;
  logic [47:0] shift_q, shift_d;
  logic [8:0]  wrdata_q, wrdata_d;
  logic        wrreq_q, wrreq_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_q, drop_d;
  logic        run_q, run_d;

  logic [USEDW_BITS:0] free_s;
  logic   run_rise_s, run_fall_s, space_ok_s, start_s;
  logic   pop_s, push_s, drop_s;
  logic   skid_full_s, skid_empty_s;
  iq_pair head_s, push_data_s;

  assign push_data_s = {i_data, q_data};
  assign free_s      = DEPTH_W - {1'b0, fifo_wrusedw};

  ddc_sample_skid u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (run_fall_s),
    .head      (head_s),
    .full      (skid_full_s),
    .empty     (skid_empty_s)
  );

  // Run edge decode, sample-start qualification and strobe admission
  always_comb begin
    run_d      = run;
    run_rise_s = run & ~run_q;
    run_fall_s = ~run & run_q;
    space_ok_s = (free_s >= NEED_W);
    start_s    = ~skid_empty_s & run & space_ok_s;
    pop_s      = start_s & ((state_q == ST_IDLE) | (state_q == ST_B5));
    push_s     = sample_strobe & run & (~skid_full_s | pop_s);
    drop_s     = sample_strobe & run & skid_full_s & ~pop_s;
  end

  // Serialiser next state; once B0 is entered the sample always runs to B5
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_B0;
          shift_d = head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_B0: begin state_d = ST_B1; shift_d = {shift_q[39:0], 8'h00}; end
      ST_B1: begin state_d = ST_B2; shift_d = {shift_q[39:0], 8'h00}; end
      ST_B2: begin state_d = ST_B3; shift_d = {shift_q[39:0], 8'h00}; end
      ST_B3: begin state_d = ST_B4; shift_d = {shift_q[39:0], 8'h00}; end
      ST_B4: begin state_d = ST_B5; shift_d = {shift_q[39:0], 8'h00}; end
      ST_B5: begin
        if (start_s) begin
          state_d = ST_B0;
          shift_d = head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = 48'h0;
      end
    endcase
  end

  // Registered FIFO write port and drop/overflow bookkeeping
  always_comb begin
    wrreq_d    = (state_d != ST_IDLE);
    wrdata_d   = 9'h000;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (state_d != ST_IDLE) begin
      wrdata_d[SAMPLE_START_BIT] = (state_d == ST_B0);
      wrdata_d[7:0]              = shift_d[47:40];
    end else begin
      wrdata_d = 9'h000;
    end
    if (run_rise_s) begin
      overflow_d = 1'b0;
      drop_d     = 16'h0000;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      overflow_d = overflow_q;
      drop_d     = drop_q;
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 48'h0;
      wrdata_q   <= 9'h000;
      wrreq_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 16'h0000;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      wrdata_q   <= wrdata_d;
      wrreq_q    <= wrreq_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      run_q      <= run_d;
    end
  end

  assign fifo_wrdata = wrdata_q;
  assign fifo_wrreq  = wrreq_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign busy        = (state_q != ST_IDLE) | ~skid_empty_s;

endmodule

// File: tb/tb_ddc_sample_packer.sv
// Directed bench for ddc_sample_packer: FIFO writes are captured on the
// falling edge with their cycle number and compared against hand-built
// expected byte streams.
module tb_ddc_sample_packer;
  import sdr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        sample_strobe;
  logic [23:0] i_data;
  logic [23:0] q_data;
  logic [11:0] fifo_wrusedw;
  logic [8:0]  fifo_wrdata;
  logic        fifo_wrreq;
  logic        overflow;
  logic [15:0] drop_count;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0] cap_data[$];
  int         cap_cyc[$];
  logic [8:0] exp_q[$];

  ddc_sample_packer dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .sample_strobe (sample_strobe),
    .i_data        (i_data),
    .q_data        (q_data),
    .fifo_wrusedw  (fifo_wrusedw),
    .fifo_wrdata   (fifo_wrdata),
    .fifo_wrreq    (fifo_wrreq),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // Capture every FIFO write with the cycle it occurred in
  always @(negedge clock) begin
    if (fifo_wrreq) begin
      cap_data.push_back(fifo_wrdata);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_word(input logic [23:0] iv, input logic [23:0] qv, input int j);
    logic [47:0] p;
    p = {iv, qv};
    return {(j == 0), p[47 - 8*j -: 8]};
  endfunction

  task automatic push_expected(input logic [23:0] iv, input logic [23:0] qv);
    for (int j = 0; j < 6; j++) exp_q.push_back(exp_word(iv, qv, j));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic strobe(input logic [23:0] iv, input logic [23:0] qv);
    i_data        = iv;
    q_data        = qv;
    sample_strobe = 1'b1;
    @(negedge clock);
    sample_strobe = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int base);
    int bad;
    check_value({tag, "_count"}, cap_data.size() - base, exp_q.size());
    bad = 0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (base + j >= cap_data.size()) bad++;
      else if (cap_data[base + j] !== exp_q[j]) bad++;
    end
    check_value({tag, "_words_bad"}, bad, 0);
    exp_q.delete();
  endtask

  initial begin
    int base, s_cyc, gaps, marks, found;
    logic [8:0] single_exp [6];
    logic [23:0] iv, qv;

    single_exp = '{9'h112, 9'h034, 9'h056, 9'h089, 9'h0AB, 9'h0CD};
    reset = 1'b1; run = 1'b0; sample_strobe = 1'b0;
    i_data = 24'h0; q_data = 24'h0; fifo_wrusedw = 12'd0;
    tick(3);
    check_value("rst_wrreq",  fifo_wrreq,  0);
    check_value("rst_wrdata", fifo_wrdata, 0);
    check_value("rst_ovf",    overflow,    0);
    check_value("rst_drops",  drop_count,  0);
    check_value("rst_busy",   busy,        0);
    reset = 1'b0;
    run   = 1'b1;
    tick(2);

    // Single sample: exact bytes, latency 2, back-to-back bytes
    base  = cap_data.size();
    s_cyc = cyc;
    strobe(24'h123456, 24'h89ABCD);
    tick(12);
    check_value("single_count", cap_data.size() - base, 6);
    for (int j = 0; j < 6; j++)
      check_value($sformatf("single_w%0d", j),
                  (base + j < cap_data.size()) ? cap_data[base + j] : 9'h1FF, single_exp[j]);
    if (cap_data.size() - base >= 6) begin
      check_value("single_latency", cap_cyc[base] - s_cyc, 2);
      check_value("single_span", cap_cyc[base + 5] - cap_cyc[base], 5);
    end else begin
      check_value("single_span_missing", cap_data.size() - base, 6);
    end
    check_value("single_busy_after", busy, 0);

    // Strobe while run is low is ignored and not counted
    run = 1'b0;
    tick(2);
    base = cap_data.size();
    strobe(24'hDEAD01, 24'hBEEF02);
    tick(10);
    check_value("norun_writes", cap_data.size() - base, 0);
    check_value("norun_drops", drop_count, 0);
    check_value("norun_busy", busy, 0);
    run = 1'b1;
    tick(2);

    // Continuous rate: one strobe every 6 clocks for a full frame
    base = cap_data.size();
    for (int s = 0; s < SAMPLES_PER_FRAME; s++) begin
      iv = 24'(s * 7919 + 24'h010203);
      qv = 24'(~(s * 3571) ^ 24'h5A5A5A);
      push_expected(iv, qv);
      strobe(iv, qv);
      tick(5);
    end
    tick(12);
    check_value("frame_bytes", cap_data.size() - base, FRAME_PAYLOAD_BYTES);
    gaps  = 0;
    marks = 0;
    for (int j = base; j < cap_data.size(); j++) begin
      if (j > base && cap_cyc[j] != cap_cyc[j - 1] + 1) gaps++;
      if (cap_data[j][8]) marks++;
    end
    check_value("frame_gaps", gaps, 0);
    check_value("frame_marks", marks, SAMPLES_PER_FRAME);
    check_stream("frame", base);
    check_value("frame_drops", drop_count, 0);
    check_value("frame_ovf", overflow, 0);

    // Overflow: four back-to-back strobes, fourth dropped
    base = cap_data.size();
    push_expected(24'hA00001, 24'hA00002);
    push_expected(24'hB00001, 24'hB00002);
    push_expected(24'hC00001, 24'hC00002);
    strobe(24'hA00001, 24'hA00002);
    strobe(24'hB00001, 24'hB00002);
    strobe(24'hC00001, 24'hC00002);
    strobe(24'hD00001, 24'hD00002);
    tick(30);
    check_stream("ovf", base);
    check_value("ovf_drops", drop_count, 1);
    check_value("ovf_flag", overflow, 1);
    check_value("ovf_busy_after", busy, 0);

    // Run falls during B1 with two entries buffered
    base = cap_data.size();
    push_expected(24'h111111, 24'h222222);
    strobe(24'h111111, 24'h222222);
    strobe(24'h333333, 24'h444444);
    strobe(24'h555555, 24'h666666);
    run = 1'b0;
    tick(20);
    check_stream("runfall", base);
    check_value("runfall_busy", busy, 0);
    check_value("runfall_drops_kept", drop_count, 1);
    check_value("runfall_ovf_kept", overflow, 1);
    run = 1'b1;
    tick(1);
    check_value("runrise_drops", drop_count, 0);
    check_value("runrise_ovf", overflow, 0);
    tick(2);

    // FIFO space: held off at 8 free words, starts at exactly 10 free
    fifo_wrusedw = 12'd4088;
    base = cap_data.size();
    push_expected(24'h7FFFFF, 24'h800000);
    strobe(24'h7FFFFF, 24'h800000);
    tick(10);
    check_value("space_hold_writes", cap_data.size() - base, 0);
    check_value("space_hold_busy", busy, 1);
    fifo_wrusedw = 12'd4086;
    found = 0;
    for (int t = 0; t < 10 && found == 0; t++) begin
      @(negedge clock);
      if (fifo_wrreq && fifo_wrdata[8]) found = 1;
    end
    check_value("space_start_seen", found, 1);
    tick(2);
    fifo_wrusedw = 12'd4095;
    tick(12);
    check_stream("space", base);
    check_value("space_busy_after", busy, 0);
    fifo_wrusedw = 12'd0;
    tick(2);

    // Asynchronous reset during B3, then recovery
    strobe(24'hFEDCBA, 24'h987654);
    tick(4);
    check_value("prerst_wrreq", fifo_wrreq, 1);
    check_value("prerst_b3", fifo_wrdata, exp_word(24'hFEDCBA, 24'h987654, 3));
    reset = 1'b1;
    #1;
    check_value("midrst_wrreq", fifo_wrreq, 0);
    check_value("midrst_wrdata", fifo_wrdata, 0);
    check_value("midrst_busy", busy, 0);
    check_value("midrst_drops", drop_count, 0);
    check_value("midrst_ovf", overflow, 0);
    tick(2);
    reset = 1'b0;
    tick(2);
    base = cap_data.size();
    push_expected(24'h0A0B0C, 24'hF0E0D0);
    strobe(24'h0A0B0C, 24'hF0E0D0);
    tick(12);
    check_stream("postrst", base);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
